// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control path.
// No logic; no latency; no flow control.
// Enum order matches the state_o debug encoding.
package control_pkg;

    localparam int SRCB_BITS  = 3;
    localparam int ALUOP_BITS = 3;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        WB_MEM   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    typedef logic [SRCB_BITS-1:0] srcb_t;
    localparam srcb_t SRCB_REGB  = 3'd0;
    localparam srcb_t SRCB_FOUR  = 3'd1;
    localparam srcb_t SRCB_ZIMM  = 3'd2;
    localparam srcb_t SRCB_SIMM  = 3'd3;
    localparam srcb_t SRCB_FLAG  = 3'd4;
    localparam srcb_t SRCB_BOFF  = 3'd5;
    localparam srcb_t SRCB_SHAMT = 3'd6;

    typedef logic [ALUOP_BITS-1:0] aluop_t;
    localparam aluop_t ALU_ADD = 3'd0;
    localparam aluop_t ALU_SUB = 3'd1;
    localparam aluop_t ALU_AND = 3'd2;
    localparam aluop_t ALU_OR  = 3'd3;
    localparam aluop_t ALU_SLT = 3'd4;
    localparam aluop_t ALU_SLL = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation / operand-B decode for R-type funct and ALU-immediate opcodes.
// Combinational, zero latency; no flow control.
// valid=0 flags an unsupported funct/opcode so the FSM can trap.
module alu_decoder
    import control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output aluop_t     alu_op,
    output srcb_t      srcb,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_ADD;
        srcb   = SRCB_REGB;
        valid  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                valid = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL: begin
                        alu_op = ALU_SLL;
                        srcb   = SRCB_SHAMT;
                    end
                    default: valid = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_op = ALU_ADD;
                srcb   = SRCB_SIMM;
                valid  = 1'b1;
            end
            OP_ANDI: begin
                alu_op = ALU_AND;
                srcb   = SRCB_ZIMM;
                valid  = 1'b1;
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM sequencing fetch/decode/execute/writeback of the multicycle datapath.
// 3-5 cycles per instruction with zero-wait memory, +1 per memory wait cycle.
// Memory requests are held stable until mem_ready; mem_ready is ignored when no request is up.
module multicycle_control
    import control_pkg::*;
#(
    parameter int SRCB_W  = 3,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_source,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [SRCB_W-1:0]  alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic [3:0]         state_o
);

    state_t state_q, state_d;
    logic   illegal_q;
    aluop_t dec_op;
    srcb_t  dec_srcb;
    logic   dec_valid;
    srcb_t  srcb;
    aluop_t aop;

    alu_decoder u_alu_decoder (
        .opcode (opcode),
        .funct  (funct),
        .alu_op (dec_op),
        .srcb   (dec_srcb),
        .valid  (dec_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == TRAP);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:        state_d = EXEC_R;
                    OP_ADDI, OP_ANDI: state_d = EXEC_I;
                    OP_LW, OP_SW:    state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE:  state_d = BRANCH;
                    OP_J:            state_d = JUMP;
                    default:         state_d = TRAP;
                endcase
            end
            EXEC_R:   state_d = dec_valid ? WB_R : TRAP;
            EXEC_I:   state_d = dec_valid ? WB_I : TRAP;
            MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_d = WB_MEM;
            MEM_WR:   if (mem_ready) state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
    end

    // Outputs are forced low asynchronously while reset is held.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'd0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        srcb       = SRCB_REGB;
        aop        = ALU_ADD;
        if (reset_n) begin
            case (state_q)
                FETCH: begin
                    mem_req  = 1'b1;
                    srcb     = SRCB_FOUR;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                DECODE:   srcb = SRCB_BOFF;
                EXEC_R, EXEC_I: begin
                    alu_src_a = 1'b1;
                    srcb      = dec_srcb;
                    aop       = dec_op;
                end
                WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                WB_I:     reg_write = 1'b1;
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    srcb      = SRCB_SIMM;
                end
                MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WR: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    aop       = ALU_SUB;
                    pc_source = 2'd1;
                    pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign alu_src_b = SRCB_W'(srcb);
    assign alu_op    = ALUOP_W'(aop);
    assign illegal   = illegal_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected control sequences built from the
// instruction-class rules, applied with random memory waits and checked every cycle.
module tb_multicycle_control;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal;
        logic [3:0] st;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_source;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [2:0] alu_src_b, alu_op;
    logic [3:0] state_o;

    int   vectors = 0;
    int   miscompares = 0;
    ctl_t obs;
    ctl_t c;
    ctl_t eq[$];
    bit   mq[$];
    bit   cur_trap;

    multicycle_control #(.SRCB_W(3), .ALUOP_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_source, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, state_o};

    task automatic check(input ctl_t exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input ctl_t v, input bit rdy);
        v.illegal = v.illegal | cur_trap;
        eq.push_back(v);
        mq.push_back(rdy);
    endtask

    // A memory access: waits cycles with mem_ready low, then one accepting cycle.
    task automatic add_mem(input bit fetch, input bit we, input int waits, input logic [3:0] st);
        ctl_t v;
        v = '0;
        v.mem_req = 1'b1;
        v.st = st;
        if (fetch) v.alu_src_b = 3'd1;
        else begin
            v.iord = 1'b1;
            v.mem_we = we;
        end
        for (int i = 0; i < waits; i++) push(v, 1'b0);
        if (fetch) begin
            v.ir_write = 1'b1;
            v.pc_write = 1'b1;
        end
        push(v, 1'b1);
    endtask

    task automatic add_trap(input int n);
        ctl_t v;
        cur_trap = 1'b1;
        for (int i = 0; i < n; i++) begin
            v = '0;
            v.st = 4'd12;
            push(v, 1'($urandom));
        end
    endtask

    // Expected per-cycle control vectors for one instruction.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit z,
                         input int fw, input int mw);
        ctl_t v;
        bit   ok;
        logic [2:0] aop;
        add_mem(1'b1, 1'b0, fw, 4'd0);
        v = '0; v.st = 4'd1; v.alu_src_b = 3'd5; push(v, 1'($urandom));
        case (op)
            6'h00: begin
                ok = 1'b1; aop = 3'd0;
                case (fn)
                    6'h20: aop = 3'd0;
                    6'h22: aop = 3'd1;
                    6'h24: aop = 3'd2;
                    6'h25: aop = 3'd3;
                    6'h2A: aop = 3'd4;
                    6'h00: aop = 3'd5;
                    default: ok = 1'b0;
                endcase
                v = '0; v.st = 4'd2; v.alu_src_a = 1'b1; v.alu_op = aop;
                v.alu_src_b = (fn == 6'h00) ? 3'd6 : 3'd0;
                push(v, 1'($urandom));
                if (ok) begin
                    v = '0; v.st = 4'd3; v.reg_write = 1'b1; v.reg_dst = 1'b1;
                    push(v, 1'($urandom));
                end else add_trap(3);
            end
            6'h08, 6'h0C: begin
                v = '0; v.st = 4'd4; v.alu_src_a = 1'b1;
                v.alu_src_b = (op == 6'h08) ? 3'd3 : 3'd2;
                v.alu_op    = (op == 6'h08) ? 3'd0 : 3'd2;
                push(v, 1'($urandom));
                v = '0; v.st = 4'd5; v.reg_write = 1'b1; push(v, 1'($urandom));
            end
            6'h23, 6'h2B: begin
                v = '0; v.st = 4'd6; v.alu_src_a = 1'b1; v.alu_src_b = 3'd3;
                push(v, 1'($urandom));
                if (op == 6'h23) begin
                    add_mem(1'b0, 1'b0, mw, 4'd7);
                    v = '0; v.st = 4'd8; v.reg_write = 1'b1; v.mem_to_reg = 1'b1;
                    push(v, 1'($urandom));
                end else add_mem(1'b0, 1'b1, mw, 4'd9);
            end
            6'h04, 6'h05: begin
                v = '0; v.st = 4'd10; v.alu_src_a = 1'b1; v.alu_op = 3'd1; v.pc_source = 2'd1;
                v.pc_write = (op == 6'h04) ? z : ~z;
                push(v, 1'($urandom));
            end
            6'h02: begin
                v = '0; v.st = 4'd11; v.pc_write = 1'b1; v.pc_source = 2'd2;
                push(v, 1'($urandom));
            end
            default: add_trap(4);
        endcase
    endtask

    task automatic apply(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input bit z, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            opcode = op; funct = fn; zero = z; mem_ready = mq[i];
            #1 check(eq[i], $sformatf("%s[%0d]", name, i));
        end
        eq.delete();
        mq.delete();
    endtask

    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input bit z, input int fw, input int mw);
        build(op, fn, z, fw, mw);
        apply(name, op, fn, z, eq.size());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; mem_ready = 1'b0;
        #1 check('0, "reset");
        #2 reset_n = 1'b1;
        cur_trap = 1'b0;
    endtask

    logic [5:0] ops[8] = '{6'h00, 6'h08, 6'h0C, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    logic [5:0] fns[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

    initial begin
        ctl_t fw;
        cur_trap = 1'b0;
        do_reset();

        run("add", 6'h00, 6'h20, 1'b0, 0, 0);
        run("lw_wait2", 6'h23, 6'h00, 1'b0, 0, 2);
        run("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0);
        run("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0);
        run("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0);
        run("bne_z0", 6'h05, 6'h00, 1'b0, 0, 0);
        run("andi", 6'h0C, 6'h00, 1'b0, 0, 0);
        run("sll", 6'h00, 6'h00, 1'b0, 1, 0);
        run("j", 6'h02, 6'h00, 1'b0, 2, 0);
        run("sw_wait1", 6'h2B, 6'h00, 1'b0, 0, 1);

        for (int k = 0; k < 80; k++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 7)];
            fn = fns[$urandom_range(0, 5)];
            run($sformatf("rnd%0d_op%02h", k, op), op, fn, 1'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, $urandom_range(0, 3));
        end

        // Abort a store while it waits on memory.
        build(6'h2B, 6'h00, 1'b0, 0, 3);
        apply("sw_abort", 6'h2B, 6'h00, 1'b0, 5);
        #2 reset_n = 1'b0;
        #1 check('0, "async_reset_drop");
        @(negedge clk);
        #1 check('0, "reset_hold");
        #2 reset_n = 1'b1;
        fw = '0; fw.mem_req = 1'b1; fw.alu_src_b = 3'd1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1 check(fw, "fetch_after_abort");
        run("add_after_abort", 6'h00, 6'h22, 1'b0, 0, 0);

        run("trap_op3f", 6'h3F, 6'h00, 1'b0, 0, 0);
        do_reset();
        run("or_after_trap", 6'h00, 6'h25, 1'b0, 0, 0);
        run("trap_fn3f", 6'h00, 6'h3F, 1'b1, 0, 0);
        do_reset();
        run("slt_final", 6'h00, 6'h2A, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
